// File: rtl/fpga_fetch_pkg.sv
// Shared types and default widths for the fetch stage and the test executor it feeds.
package fpga_fetch_pkg;

    localparam int ADDR_W_DEF  = 10;
    localparam int INSTR_W_DEF = 32;
    localparam int DEPTH_DEF   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0]  ip;
    } fetch_entry_t;

endpackage

// File: rtl/fpga_fetch_if.sv
// Fetch-stage bus: program memory read port, instruction handshake to the executor, jump redirect.
interface fpga_fetch_if
    import fpga_fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic               mem_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_data;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_ip;
    logic               jump_valid;
    logic [ADDR_W:0]    jump_target;

    modport master (
        output mem_en, mem_addr, instr_valid, instr, instr_ip,
        input  mem_data, instr_ready, jump_valid, jump_target
    );

    modport slave (
        input  mem_en, mem_addr, instr_valid, instr, instr_ip,
        output mem_data, instr_ready, jump_valid, jump_target
    );

endinterface

// File: rtl/fpga_fetch_fifo.sv
// Prefetch FIFO of {instr, ip} entries with a registered head and single-cycle flush.
// Latency: a push is visible at the head the next cycle; push and pop may share a cycle.
// Backpressure: a push into a full FIFO is dropped unless a pop frees a slot the same cycle.
module fpga_fetch_fifo
    import fpga_fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           din,
    output fetch_entry_t           head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset: the occupancy count qualifies every read.
    always_ff @(posedge clock) begin
        if (w_do_push && !reset && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/fpga_fetch.sv
// Instruction fetch: walks pc through sync-read program memory into a prefetch FIFO (FPGA_FETCH_PERF_EN adds stall/bubble counters).
// Latency: first read one cycle after start, first instruction two cycles after that read; one per cycle steady state.
// Backpressure: reads stop once FIFO occupancy plus the in-flight read would exceed DEPTH; head holds while stalled.
module fpga_fetch
    import fpga_fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [ADDR_W:0] program_size,
    fpga_fetch_if.master    bus,
    output logic            busy,
    output logic            done
`ifdef FPGA_FETCH_PERF_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     bubble_cycles
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t       r_state;
    logic [ADDR_W:0]    r_pc;
    logic [ADDR_W:0]    r_size;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_inflight_ip;

    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;
    logic [CW-1:0]      w_count;
    logic               w_empty;
    logic               w_run;
    logic               w_flush;
    logic               w_stale;
    logic               w_push;
    logic               w_pop;
    logic [CW:0]        w_used;
    logic [CW:0]        w_limit;
    logic               w_credit_ok;
    logic               w_issue;
    logic               w_drained;
    logic [INSTR_W-1:0] w_head_instr;
    logic [ADDR_W-1:0]  w_head_ip;

    assign w_run   = (r_state == RUN);
    assign w_flush = start || (w_run && bus.jump_valid);
    assign w_pop   = !w_empty && bus.instr_ready;

    // A read returning in a redirect cycle belongs to the abandoned stream.
    assign w_stale = w_flush;
    assign w_push  = r_inflight && !w_stale;

    assign w_used      = {1'b0, w_count} + (CW+1)'(r_inflight);
    assign w_limit     = (CW+1)'(DEPTH) + (CW+1)'(w_pop);
    assign w_credit_ok = (w_used < w_limit);

    assign w_issue   = w_run && !start && !bus.jump_valid && (r_pc < r_size) && w_credit_ok;
    assign w_drained = (r_pc >= r_size) && !r_inflight && w_empty;

    assign w_push_entry = {bus.mem_data, r_inflight_ip};

    fpga_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (w_push_entry),
        .head  (w_head),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= '0;
            r_size        <= '0;
            r_inflight    <= 1'b0;
            r_inflight_ip <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_ip <= r_pc[ADDR_W-1:0];
                r_pc          <= r_pc + 1'b1;
            end
            if (start) begin
                r_state <= RUN;
                r_pc    <= '0;
                r_size  <= program_size;
            end else if (w_run) begin
                if (bus.jump_valid) begin
                    r_pc <= bus.jump_target;
                end else if (w_drained) begin
                    r_state <= DONE;
                end
            end
        end
    end

    assign w_head_instr = w_head.instr;
    assign w_head_ip    = w_head.ip;

    assign bus.mem_en      = w_issue;
    assign bus.mem_addr    = w_issue ? r_pc[ADDR_W-1:0] : '0;
    assign bus.instr_valid = !w_empty;
    assign bus.instr       = w_empty ? '0 : w_head_instr;
    assign bus.instr_ip    = w_empty ? '0 : w_head_ip;

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

`ifdef FPGA_FETCH_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_bubble_cycles;

    always_ff @(posedge clock) begin
        if (reset || start) begin
            r_stall_cycles  <= '0;
            r_bubble_cycles <= '0;
        end else begin
            if (!w_empty && !bus.instr_ready && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_run && w_empty && (r_bubble_cycles != '1)) begin
                r_bubble_cycles <= r_bubble_cycles + 1'b1;
            end
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign bubble_cycles = r_bubble_cycles;
`endif

endmodule

// File: tb/tb_fpga_fetch.sv
// Bench for fpga_fetch: directed latency/backpressure/jump/reset scenarios plus randomized stream scoreboard.
module tb_fpga_fetch;
    import fpga_fetch_pkg::*;

    localparam int AW    = 10;
    localparam int IW    = 32;
    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [AW:0] program_size;
    logic        busy;
    logic        done;
`ifdef FPGA_FETCH_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] bubble_cycles;
`endif

    int checks = 0;
    int errors = 0;
    logic [IW-1:0] prog [1<<AW];

    fpga_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    fpga_fetch #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .program_size (program_size),
        .bus          (bus),
        .busy         (busy),
        .done         (done)
`ifdef FPGA_FETCH_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .bubble_cycles(bubble_cycles)
`endif
    );

    always #5 clock = ~clock;

    // Synchronous-read program memory model
    always @(posedge clock) begin
        if (bus.mem_en) bus.mem_data <= prog[bus.mem_addr];
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic kick(input int size, input logic rdy);
        start            = 1'b1;
        program_size     = (AW+1)'(size);
        bus.instr_ready  = rdy;
        bus.jump_valid   = 1'b0;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        #1;
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b want 0", bus.mem_en); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.instr_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
        checks++; if (bus.mem_addr !== '0 || bus.instr !== '0 || bus.instr_ip !== '0) begin
            errors++; $display("FAIL reset_data got addr=%0d instr=%h ip=%0d want 0", bus.mem_addr, bus.instr, bus.instr_ip);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic want;
        kick(4, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            #1;
            want = (k >= 1 && k <= 4);
            checks++; if (bus.mem_en !== want) begin errors++; $display("FAIL basic_mem_en k=%0d got %b want %b", k, bus.mem_en, want); end
            if (want) begin
                checks++; if (bus.mem_addr !== AW'(k-1)) begin errors++; $display("FAIL basic_addr k=%0d got %0d want %0d", k, bus.mem_addr, k-1); end
            end
            want = (k >= 3 && k <= 6);
            checks++; if (bus.instr_valid !== want) begin errors++; $display("FAIL basic_valid k=%0d got %b want %b", k, bus.instr_valid, want); end
            if (want) begin
                checks++; if (bus.instr_ip !== AW'(k-3) || bus.instr !== prog[k-3]) begin
                    errors++; $display("FAIL basic_word k=%0d got ip=%0d instr=%h want ip=%0d instr=%h", k, bus.instr_ip, bus.instr, k-3, prog[k-3]);
                end
            end
            if (k == 6) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_early_done got %b want 0", done); end
            end
            step();
        end
        #1;
        checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_done got done=%b busy=%b want 1 1", done, busy); end
        step();
    endtask

    task automatic test_backpressure();
        int nxt, issued, accepted;
        logic prev_stall;
        logic [AW-1:0] prev_ip;
        logic [IW-1:0] prev_instr;
        nxt = 0; issued = 0; accepted = 0; prev_stall = 1'b0; prev_ip = '0; prev_instr = '0;
        kick(8, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            bus.instr_ready = !(k >= 3 && k <= 7);
            #1;
            if (prev_stall) begin
                checks++; if (bus.instr_valid !== 1'b1 || bus.instr_ip !== prev_ip || bus.instr !== prev_instr) begin
                    errors++; $display("FAIL bp_hold k=%0d got v=%b ip=%0d want v=1 ip=%0d", k, bus.instr_valid, bus.instr_ip, prev_ip);
                end
            end
            if (k >= 3 && k <= 7) begin
                checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL bp_mem_en k=%0d got %b want 0", k, bus.mem_en); end
            end
            if (bus.instr_valid === 1'b1 && bus.instr_ready) begin
                checks++; if (bus.instr_ip !== AW'(nxt) || bus.instr !== prog[nxt]) begin
                    errors++; $display("FAIL bp_order got ip=%0d want ip=%0d", bus.instr_ip, nxt);
                end
                nxt++; accepted++;
            end
            if (bus.mem_en === 1'b1) begin
                issued++;
                checks++; if (issued - accepted > DEPTH) begin errors++; $display("FAIL bp_credit k=%0d got outstanding=%0d want <=%0d", k, issued - accepted, DEPTH); end
            end
            prev_stall = (bus.instr_valid === 1'b1) && !bus.instr_ready;
            prev_ip    = bus.instr_ip;
            prev_instr = bus.instr;
            step();
        end
        #1;
        checks++; if (accepted != 8 || done !== 1'b1) begin errors++; $display("FAIL bp_total got %0d done=%b want 8 done=1", accepted, done); end
        step();
    endtask

    task automatic test_jump();
        int exp_ip, accepted;
        exp_ip = 0; accepted = 0;
        kick(10, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            bus.jump_valid  = (k == 4);
            bus.jump_target = (AW+1)'(6);
            #1;
            if (k == 4) begin
                checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL jump_issue got mem_en=%b want 0", bus.mem_en); end
            end
            if (bus.instr_valid === 1'b1 && bus.instr_ready) begin
                checks++; if (bus.instr_ip !== AW'(exp_ip) || bus.instr !== prog[exp_ip]) begin
                    errors++; $display("FAIL jump_order got ip=%0d want ip=%0d", bus.instr_ip, exp_ip);
                end
                exp_ip++; accepted++;
            end
            if (k == 4) exp_ip = 6;
            step();
        end
        bus.jump_valid = 1'b0;
        #1;
        checks++; if (accepted != 6 || done !== 1'b1) begin errors++; $display("FAIL jump_total got %0d done=%b want 6 done=1", accepted, done); end
        step();
    endtask

    task automatic test_jump_end();
        kick(5, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            bus.instr_ready = (k >= 5);
            bus.jump_valid  = (k == 5);
            bus.jump_target = (AW+1)'(5);
            #1;
            if (k == 5) begin
                checks++; if (bus.instr_valid !== 1'b1 || bus.instr_ip !== '0 || bus.instr !== prog[0]) begin
                    errors++; $display("FAIL jend_pop got v=%b ip=%0d want v=1 ip=0", bus.instr_valid, bus.instr_ip);
                end
            end
            if (k >= 6) begin
                checks++; if (bus.instr_valid !== 1'b0 || bus.mem_en !== 1'b0) begin
                    errors++; $display("FAIL jend_quiet k=%0d got v=%b en=%b want 0 0", k, bus.instr_valid, bus.mem_en);
                end
            end
            if (k == 8) begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL jend_done got %b want 1", done); end
            end
            step();
        end
        bus.jump_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        kick(20, 1'b1);
        repeat (4) step();
        reset = 1'b1;
        step();
        #1;
        checks++; if (bus.mem_en !== 1'b0 || bus.instr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rmid_ctrl got en=%b v=%b busy=%b done=%b want 0000", bus.mem_en, bus.instr_valid, busy, done);
        end
        checks++; if (bus.mem_addr !== '0 || bus.instr !== '0 || bus.instr_ip !== '0) begin
            errors++; $display("FAIL rmid_data got addr=%0d instr=%h ip=%0d want 0", bus.mem_addr, bus.instr, bus.instr_ip);
        end
        reset = 1'b0;
        step();
        #1;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale got v=%b want 0", bus.instr_valid); end
        step();
        kick(0, 1'b1);
        #1;
        checks++; if (bus.mem_en !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL size0_c1 got en=%b done=%b want 0 0", bus.mem_en, done); end
        step();
        #1;
        checks++; if (bus.mem_en !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL size0_c2 got en=%b done=%b want 0 1", bus.mem_en, done); end
        step();
    endtask

`ifdef FPGA_FETCH_PERF_EN
    task automatic test_perf();
        kick(8, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            bus.instr_ready = (k >= 8);
            #1;
            if (k == 8) begin
                checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL perf_stall got %0d want 5", stall_cycles); end
                checks++; if (bubble_cycles !== 32'd2) begin errors++; $display("FAIL perf_bubble got %0d want 2", bubble_cycles); end
            end
            step();
        end
        kick(8, 1'b1);
        #1;
        checks++; if (stall_cycles !== 32'd0 || bubble_cycles !== 32'd0) begin
            errors++; $display("FAIL perf_clear got stall=%0d bubble=%0d want 0 0", stall_cycles, bubble_cycles);
        end
        repeat (20) step();
    endtask
`endif

    task automatic test_random();
        for (int run = 0; run < 12; run++) begin
            int size, exp_ip, jumps, tgt;
            logic finished, prev_stall, prev_jump;
            logic [AW-1:0] prev_ip;
            logic [IW-1:0] prev_instr;
            size = int'($urandom_range(1, 40));
            exp_ip = 0; jumps = 0; finished = 1'b0;
            prev_stall = 1'b0; prev_jump = 1'b0; prev_ip = '0; prev_instr = '0;
            kick(size, 1'b1);
            for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
                bus.instr_ready = ($urandom_range(0, 99) < 70);
                bus.jump_valid  = 1'b0;
                tgt = 0;
                if (jumps < 3 && done !== 1'b1 && $urandom_range(0, 99) < 6) begin
                    tgt = int'($urandom_range(0, size + 2));
                    bus.jump_valid  = 1'b1;
                    bus.jump_target = (AW+1)'(tgt);
                    jumps++;
                end
                #1;
                if (prev_stall && !prev_jump) begin
                    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_ip !== prev_ip || bus.instr !== prev_instr) begin
                        errors++; $display("FAIL rnd_hold run=%0d got v=%b ip=%0d want v=1 ip=%0d", run, bus.instr_valid, bus.instr_ip, prev_ip);
                    end
                end
                if (bus.instr_valid === 1'b1 && bus.instr_ready) begin
                    checks++; if (bus.instr_ip !== AW'(exp_ip) || bus.instr !== prog[exp_ip]) begin
                        errors++; $display("FAIL rnd_order run=%0d got ip=%0d want ip=%0d", run, bus.instr_ip, exp_ip);
                    end
                    exp_ip++;
                end
                if (bus.jump_valid) exp_ip = tgt;
                if (done === 1'b1) begin
                    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rnd_after_done run=%0d got v=%b want 0", run, bus.instr_valid); end
                    if (exp_ip >= size) finished = 1'b1;
                end
                prev_stall = (bus.instr_valid === 1'b1) && !bus.instr_ready;
                prev_jump  = bus.jump_valid;
                prev_ip    = bus.instr_ip;
                prev_instr = bus.instr;
                step();
            end
            bus.jump_valid = 1'b0;
            checks++; if (!finished) begin errors++; $display("FAIL rnd_done run=%0d got next_ip=%0d done=%b want all %0d delivered and done", run, exp_ip, done, size); end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) prog[i] = $urandom;
        reset           = 1'b1;
        start           = 1'b0;
        program_size    = '0;
        bus.instr_ready = 1'b0;
        bus.jump_valid  = 1'b0;
        bus.jump_target = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_jump();
        test_jump_end();
        test_reset_mid();
`ifdef FPGA_FETCH_PERF_EN
        test_perf();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
